// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - display bus and decoded-digit signals for seg7_capture
interface seg7_capture_if #(
    parameter int NDIGITS = 4
);
    logic [0:6]           SegIn;
    logic [NDIGITS-1:0]   DigSel;
    logic [4*NDIGITS-1:0] Digits;
    logic [NDIGITS-1:0]   DigValid;
    logic                 Update;
    logic [2:0]           UpdIdx;
    logic                 BadPat;

    // Display driver / stimulus side
    modport master (
        output SegIn, DigSel,
        input  Digits, DigValid, Update, UpdIdx, BadPat
    );

    // Capture side
    modport slave (
        input  SegIn, DigSel,
        output Digits, DigValid, Update, UpdIdx, BadPat
    );
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - multiplexed 7-segment bus capture with stability filter and decode
module seg7_capture #(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    seg7_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    // Sampled copy of the bus; the stability window compares the raw bus against it
    logic [0:6]           segReg;
    logic [NDIGITS-1:0]   selReg;
    logic [CW-1:0]        stableCnt;

    // Committed results
    logic [4*NDIGITS-1:0] digitsReg;
    logic [NDIGITS-1:0]   validReg;
    logic                 updateReg;
    logic [2:0]           updIdxReg;
    logic                 badReg;

    // Decode of the sampled bus
    logic [0:6]           pat;
    logic [3:0]           code;
    logic                 recog;
    logic [NDIGITS-1:0]   selLow;
    logic [3:0]           lowCount;
    logic [2:0]           selIdx;
    logic                 oneLow;
    logic                 multiLow;
    logic                 inChanged;
    logic                 commitAttempt;

    assign inChanged = (bus.SegIn != segReg) || (bus.DigSel != selReg);

    // The attempt fires only on the 3->4 (for the default) step, so a held value commits once
    assign commitAttempt = !inChanged && (stableCnt == CW'(STABLE_CYCLES - 1));

    // Input sampling and saturating stability counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            segReg    <= '1;
            selReg    <= '1;
            stableCnt <= '0;
        end else begin
            segReg <= bus.SegIn;
            selReg <= bus.DigSel;
            if (inChanged)
                stableCnt <= '0;
            else if (stableCnt != CW'(STABLE_CYCLES))
                stableCnt <= stableCnt + 1'b1;
        end
    end

    // Segment pattern to code; pattern literals read a..g left to right
    always_comb begin
        pat   = ~segReg;
        code  = 4'd0;
        recog = 1'b1;
        case (pat)
            7'b1111110: code = 4'd0;
            7'b0110000: code = 4'd1;
            7'b1101101: code = 4'd2;
            7'b1111001: code = 4'd3;
            7'b0110011: code = 4'd4;
            7'b1011011: code = 4'd5;
            7'b1011111: code = 4'd6;
            7'b1110000: code = 4'd7;
            7'b1111111: code = 4'd8;
            7'b1111011: code = 4'd9;
            7'b0111101: code = 4'd11;
            7'b0000001: code = 4'd15;
            default:    recog = 1'b0;
        endcase
    end

    // Count active digit selects and locate the selected position
    always_comb begin
        selLow   = ~selReg;
        lowCount = 4'd0;
        selIdx   = 3'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (selLow[i]) begin
                lowCount = lowCount + 4'd1;
                selIdx   = 3'(i);
            end
        end
        oneLow   = (lowCount == 4'd1);
        multiLow = (lowCount > 4'd1);
    end

    // Commit: write only the selected slot, pulse Update/BadPat for one cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            digitsReg <= '0;
            validReg  <= '0;
            updateReg <= 1'b0;
            updIdxReg <= 3'd0;
            badReg    <= 1'b0;
        end else begin
            updateReg <= 1'b0;
            badReg    <= 1'b0;
            if (commitAttempt) begin
                if (oneLow) begin
                    updateReg <= 1'b1;
                    updIdxReg <= selIdx;
                    badReg    <= !recog;
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (selIdx == 3'(i)) begin
                            validReg[i] <= recog;
                            if (recog)
                                digitsReg[4*i +: 4] <= code;
                        end
                    end
                end else if (multiLow) begin
                    badReg <= 1'b1;
                end
            end
        end
    end

    assign bus.Digits   = digitsReg;
    assign bus.DigValid = validReg;
    assign bus.Update   = updateReg;
    assign bus.UpdIdx   = updIdxReg;
    assign bus.BadPat   = badReg;
endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed self-checking bench for seg7_capture
module tb_seg7_capture;
    logic Clk;
    logic Reset_n;
    int   checks;
    int   errors;
    int   updCnt;
    int   badCnt;
    int   updAt;
    logic [2:0] lastIdx;

    seg7_capture_if #(.NDIGITS(4)) bus ();

    seg7_capture #(.NDIGITS(4), .STABLE_CYCLES(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive a select/pattern (active-high, a..g left to right) for n edges and log pulses
    task automatic hold(input logic [3:0] sel, input logic [0:6] pat, input int n);
        bus.DigSel = sel;
        bus.SegIn  = ~pat;
        updCnt = 0;
        badCnt = 0;
        updAt  = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.Update) begin
                updCnt++;
                updAt   = k;
                lastIdx = bus.UpdIdx;
            end
            if (bus.BadPat) badCnt++;
        end
    endtask

    int scanUpd;

    initial begin
        checks  = 0;
        errors  = 0;
        lastIdx = 3'd0;
        Reset_n = 1'b0;
        bus.DigSel = 4'b1111;
        bus.SegIn  = 7'b1111111;
        tick();
        tick();
        check("rst_digits", 32'(bus.Digits), 32'h0);
        check("rst_valid", 32'(bus.DigValid), 32'h0);
        check("rst_update", 32'(bus.Update), 32'h0);
        check("rst_bad", 32'(bus.BadPat), 32'h0);
        check("rst_idx", 32'(bus.UpdIdx), 32'h0);
        Reset_n = 1'b1;

        hold(4'b1111, 7'b0000000, 6);
        check("blank_upd", 32'(updCnt), 32'd0);
        check("blank_bad", 32'(badCnt), 32'd0);

        // Digit 3 on position 0 held 10 cycles: one commit at e0+4 (tick 5)
        hold(4'b1110, 7'b1111001, 10);
        check("one_upd", 32'(updCnt), 32'd1);
        check("one_at", 32'(updAt), 32'd5);
        check("one_idx", 32'(lastIdx), 32'd0);
        check("one_code", 32'(bus.Digits[3:0]), 32'd3);
        check("one_valid", 32'(bus.DigValid), 32'b0001);

        // Scan 6,5,4,1 on positions 0..3
        scanUpd = 0;
        hold(4'b1110, 7'b1011111, 8); scanUpd += updCnt;
        hold(4'b1101, 7'b1011011, 8); scanUpd += updCnt;
        hold(4'b1011, 7'b0110011, 8); scanUpd += updCnt;
        hold(4'b0111, 7'b0110000, 8); scanUpd += updCnt;
        check("scan_upd", 32'(scanUpd), 32'd4);
        check("scan_idx", 32'(lastIdx), 32'd3);
        check("scan_digits", 32'(bus.Digits), 32'h1456);
        check("scan_valid", 32'(bus.DigValid), 32'hF);

        // 7 on position 2 with a 3-cycle glitch to 8 mid-window
        hold(4'b1011, 7'b1110000, 2);
        check("gl_pre_upd", 32'(updCnt), 32'd0);
        hold(4'b1011, 7'b1111111, 3);
        check("gl_glitch_upd", 32'(updCnt), 32'd0);
        hold(4'b1011, 7'b1110000, 8);
        check("gl_post_upd", 32'(updCnt), 32'd1);
        check("gl_post_at", 32'(updAt), 32'd5);
        check("gl_digits", 32'(bus.Digits), 32'h1756);

        // Unrecognised pattern on position 1
        hold(4'b1101, 7'b1000000, 8);
        check("bad_upd", 32'(updCnt), 32'd1);
        check("bad_bad", 32'(badCnt), 32'd1);
        check("bad_at", 32'(updAt), 32'd5);
        check("bad_idx", 32'(lastIdx), 32'd1);
        check("bad_valid", 32'(bus.DigValid), 32'b1101);
        check("bad_digits", 32'(bus.Digits), 32'h1756);

        // Two selects low: BadPat only
        hold(4'b1100, 7'b1111111, 8);
        check("multi_upd", 32'(updCnt), 32'd0);
        check("multi_bad", 32'(badCnt), 32'd1);
        check("multi_digits", 32'(bus.Digits), 32'h1756);

        // All blanked: nothing
        hold(4'b1111, 7'b1111111, 8);
        check("blank2_upd", 32'(updCnt), 32'd0);
        check("blank2_bad", 32'(badCnt), 32'd0);

        // Special codes: dash, d, and 0
        hold(4'b0111, 7'b0000001, 8);
        check("dash_code", 32'(bus.Digits[15:12]), 32'hF);
        hold(4'b0111, 7'b0111101, 8);
        check("d_code", 32'(bus.Digits[15:12]), 32'hB);
        hold(4'b1110, 7'b1111110, 8);
        check("zero_digits", 32'(bus.Digits), 32'hB750);
        check("zero_valid", 32'(bus.DigValid), 32'b1101);

        // Reset asserted at e0+2 of a window, then the held value commits afresh
        hold(4'b1110, 7'b1101101, 2);
        Reset_n = 1'b0;
        #1;
        check("mrst_digits", 32'(bus.Digits), 32'h0);
        check("mrst_valid", 32'(bus.DigValid), 32'h0);
        check("mrst_idx", 32'(bus.UpdIdx), 32'h0);
        tick();
        Reset_n = 1'b1;
        hold(4'b1110, 7'b1101101, 8);
        check("mrst_upd", 32'(updCnt), 32'd1);
        check("mrst_at", 32'(updAt), 32'd5);
        check("mrst_code", 32'(bus.Digits), 32'h0002);
        check("mrst_valid2", 32'(bus.DigValid), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
